z3_cycle_ctrl: RTL and testbench

- Zorro III slave-cycle front end for the card; sits directly upstream of the SDRAM controller.
- Synchronises the asynchronous bus strobes, decodes the card's address space and tracks the bus cycle phase.
- Drives z3_state, ram_cycle, RW and the latched DS_n into the SDRAM controller.
- Converts the controller's dtack into the bus-side SLAVE_n, DTACK_n and data-bus output enable.

---
 rtl/z3_cycle_ctrl_pkg.sv | 20 ++
 rtl/z3_cycle_ctrl_sync.sv | 28 ++
 rtl/z3_cycle_ctrl.sv | 150 +++++++++++++++
 tb/tb_z3_cycle_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/z3_cycle_ctrl_pkg.sv
// Shared definitions for the Zorro III slave-cycle front end and the SDRAM controller.
package z3_cycle_ctrl_pkg;

    typedef enum logic [1:0] {
        Z3_IDLE  = 2'd0,
        Z3_START = 2'd1,
        Z3_DATA  = 2'd2,
        Z3_END   = 2'd3
    } z3_state_t;

    localparam int Z3_SYNC_DEFAULT    = 2;
    localparam int Z3_TIMEOUT_DEFAULT = 255;
    localparam int Z3_MATCH_DEFAULT   = 4;

    // Saturating 8-bit watchdog increment.
    function automatic logic [7:0] wd_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/z3_cycle_ctrl_sync.sv
// Multi-flop synchroniser with synchronous active-low reset to a per-bit value.
module z3_sync
    import z3_cycle_ctrl_pkg::*;
#(
    parameter int              WIDTH   = 1,
    parameter int              STAGES  = Z3_SYNC_DEFAULT,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < STAGES; i++) r_stage[i] <= RST_VAL;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/z3_cycle_ctrl.sv
// Zorro III slave-cycle front end: strobe sync, address decode, cycle phase FSM
// and conversion of the SDRAM controller's dtack into bus-side responses.
module z3_cycle_ctrl
    import z3_cycle_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = Z3_SYNC_DEFAULT,
    parameter int TIMEOUT_CYCLES  = Z3_TIMEOUT_DEFAULT,
    parameter int ADDR_MATCH_BITS = Z3_MATCH_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        FCS_n,
    input  logic [3:0]  DS_n_in,
    input  logic        DOE,
    input  logic        READ,
    input  logic [29:0] ADDR,
    input  logic        configured,
    input  logic [3:0]  base_addr,
    input  logic        dtack,
    output logic [1:0]  z3_state,
    output logic        ram_cycle,
    output logic        RW,
    output logic [3:0]  DS_n,
    output logic        SLAVE_n,
    output logic        DTACK_n,
    output logic        data_oe,
    output logic        timeout
);

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic       w_fcs_s;
    logic [3:0] w_ds_s;
    logic       w_doe_s;
    logic       w_match;
    logic       w_unused_addr;

    z3_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_fcs (
        .i_clk(CLK), .i_rst_n(RESET_n), .i_d(FCS_n), .o_q(w_fcs_s)
    );

    z3_sync #(.WIDTH(4), .STAGES(SYNC_STAGES), .RST_VAL(4'hF)) u_sync_ds (
        .i_clk(CLK), .i_rst_n(RESET_n), .i_d(DS_n_in), .o_q(w_ds_s)
    );

    z3_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_doe (
        .i_clk(CLK), .i_rst_n(RESET_n), .i_d(DOE), .o_q(w_doe_s)
    );

    // ADDR[29:26] of the port is bus address [31:28].
    assign w_match = configured &&
                     (ADDR[29 -: ADDR_MATCH_BITS] == base_addr[3 -: ADDR_MATCH_BITS]);
    assign w_unused_addr = ^ADDR[29-ADDR_MATCH_BITS:0];

    z3_state_t  r_state;
    logic       r_ram_cycle;
    logic       r_rw;
    logic [3:0] r_ds_n;
    logic       r_slave_n;
    logic       r_dtack_n;
    logic       r_data_oe;
    logic       r_timeout;
    logic [7:0] r_wd;

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            r_state     <= Z3_IDLE;
            r_ram_cycle <= 1'b0;
            r_rw        <= 1'b1;
            r_ds_n      <= 4'hF;
            r_slave_n   <= 1'b1;
            r_dtack_n   <= 1'b1;
            r_data_oe   <= 1'b0;
            r_timeout   <= 1'b0;
            r_wd        <= 8'd0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                Z3_IDLE: begin
                    if (!w_fcs_s) begin
                        if (w_match) begin
                            r_state     <= Z3_START;
                            r_ram_cycle <= 1'b1;
                            r_rw        <= READ;
                            r_slave_n   <= 1'b0;
                        end else begin
                            r_state     <= Z3_END;
                            r_ram_cycle <= 1'b0;
                            r_slave_n   <= 1'b1;
                        end
                    end
                end
                Z3_START: begin
                    if (w_fcs_s) begin
                        r_state     <= Z3_IDLE;
                        r_ram_cycle <= 1'b0;
                        r_slave_n   <= 1'b1;
                        r_rw        <= 1'b1;
                    end else if ((w_ds_s != 4'hF) && w_doe_s) begin
                        r_state <= Z3_DATA;
                        r_ds_n  <= w_ds_s;
                        r_wd    <= 8'd0;
                    end
                end
                Z3_DATA: begin
                    // Bus release beats dtack; dtack beats watchdog expiry.
                    if (w_fcs_s) begin
                        r_state     <= Z3_END;
                        r_ram_cycle <= 1'b0;
                        r_slave_n   <= 1'b1;
                        r_dtack_n   <= 1'b1;
                        r_data_oe   <= 1'b0;
                    end else if (dtack) begin
                        r_dtack_n <= 1'b0;
                        r_data_oe <= r_rw && w_doe_s;
                    end else if (r_dtack_n && (r_wd == WD_LAST)) begin
                        r_state     <= Z3_END;
                        r_ram_cycle <= 1'b0;
                        r_slave_n   <= 1'b1;
                        r_data_oe   <= 1'b0;
                        r_timeout   <= 1'b1;
                    end else begin
                        r_data_oe <= r_rw && w_doe_s;
                        if (r_dtack_n) r_wd <= wd_inc(r_wd);
                    end
                end
                Z3_END: begin
                    r_ram_cycle <= 1'b0;
                    // Latched cycle attributes return to idle values with the bus.
                    if (w_fcs_s) begin
                        r_state <= Z3_IDLE;
                        r_rw    <= 1'b1;
                        r_ds_n  <= 4'hF;
                    end
                end
                default: r_state <= Z3_IDLE;
            endcase
        end
    end

    assign z3_state  = r_state;
    assign ram_cycle = r_ram_cycle;
    assign RW        = r_rw;
    assign DS_n      = r_ds_n;
    assign SLAVE_n   = r_slave_n;
    assign DTACK_n   = r_dtack_n;
    assign data_oe   = r_data_oe;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_z3_cycle_ctrl.sv
// Scoreboard bench for z3_cycle_ctrl: each step queues the expected output word and compares it after the edge.
module tb_z3_cycle_ctrl;

    logic        CLK;
    logic        RESET_n;
    logic        FCS_n;
    logic [3:0]  DS_n_in;
    logic        DOE;
    logic        READ;
    logic [29:0] ADDR;
    logic        configured;
    logic [3:0]  base_addr;
    logic        dtack;
    logic [1:0]  z3_state;
    logic        ram_cycle;
    logic        RW;
    logic [3:0]  DS_n;
    logic        SLAVE_n;
    logic        DTACK_n;
    logic        data_oe;
    logic        timeout;

    z3_cycle_ctrl dut (
        .CLK(CLK), .RESET_n(RESET_n), .FCS_n(FCS_n), .DS_n_in(DS_n_in), .DOE(DOE),
        .READ(READ), .ADDR(ADDR), .configured(configured), .base_addr(base_addr),
        .dtack(dtack), .z3_state(z3_state), .ram_cycle(ram_cycle), .RW(RW),
        .DS_n(DS_n), .SLAVE_n(SLAVE_n), .DTACK_n(DTACK_n), .data_oe(data_oe),
        .timeout(timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [11:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_END = 2'd3;

    // Word layout: {state, ram_cycle, RW, DS_n, SLAVE_n, DTACK_n, data_oe, timeout}
    function automatic logic [11:0] pk(input logic [1:0] st, input logic rc, input logic rw,
                                       input logic [3:0] ds, input logic sl, input logic dt,
                                       input logic oe, input logic to);
        return {st, rc, rw, ds, sl, dt, oe, to};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {z3_state, ram_cycle, RW, DS_n, SLAVE_n, DTACK_n, data_oe, timeout};
    endfunction

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [11:0] e);
        exp_t x;
        sb.push_back('{tag, e});
        @(posedge CLK);
        #1;
        x = sb.pop_front();
        check_eq(x.tag, dut_vec(), x.v);
    endtask

    logic [11:0] W_IDLE;

    initial begin
        W_IDLE     = pk(S_IDLE, 0, 1, 4'hF, 1, 1, 0, 0);
        RESET_n    = 1'b0;
        FCS_n      = 1'b1;
        DS_n_in    = 4'hF;
        DOE        = 1'b0;
        READ       = 1'b1;
        ADDR       = {4'h4, 26'h0};
        configured = 1'b1;
        base_addr  = 4'h4;
        dtack      = 1'b0;

        @(posedge CLK); #1;
        step("reset", W_IDLE);
        RESET_n = 1'b1;

        // Matched read
        FCS_n = 1'b0;
        step("rd_sync1", W_IDLE);
        step("rd_sync2", W_IDLE);
        step("rd_start", pk(S_START, 1, 1, 4'hF, 0, 1, 0, 0));
        DS_n_in = 4'h0; DOE = 1'b1;
        step("rd_ds1", pk(S_START, 1, 1, 4'hF, 0, 1, 0, 0));
        step("rd_ds2", pk(S_START, 1, 1, 4'hF, 0, 1, 0, 0));
        step("rd_data", pk(S_DATA, 1, 1, 4'h0, 0, 1, 0, 0));
        dtack = 1'b1;
        step("rd_dtack", pk(S_DATA, 1, 1, 4'h0, 0, 0, 1, 0));
        dtack = 1'b0;
        step("rd_dtack_hold", pk(S_DATA, 1, 1, 4'h0, 0, 0, 1, 0));
        FCS_n = 1'b1; DS_n_in = 4'hF; DOE = 1'b0;
        step("rd_rel1", pk(S_DATA, 1, 1, 4'h0, 0, 0, 1, 0));
        step("rd_rel2", pk(S_DATA, 1, 1, 4'h0, 0, 0, 1, 0));
        step("rd_end", pk(S_END, 0, 1, 4'h0, 1, 1, 0, 0));
        step("rd_idle", W_IDLE);

        // Byte write; later strobe changes must not alter the latched DS_n
        READ = 1'b0; FCS_n = 1'b0;
        step("wr_sync1", W_IDLE);
        step("wr_sync2", W_IDLE);
        step("wr_start", pk(S_START, 1, 0, 4'hF, 0, 1, 0, 0));
        DS_n_in = 4'hE; DOE = 1'b1;
        step("wr_ds1", pk(S_START, 1, 0, 4'hF, 0, 1, 0, 0));
        step("wr_ds2", pk(S_START, 1, 0, 4'hF, 0, 1, 0, 0));
        step("wr_data", pk(S_DATA, 1, 0, 4'hE, 0, 1, 0, 0));
        dtack = 1'b1; DS_n_in = 4'h0;
        step("wr_dtack", pk(S_DATA, 1, 0, 4'hE, 0, 0, 0, 0));
        dtack = 1'b0;
        step("wr_ds_ignored", pk(S_DATA, 1, 0, 4'hE, 0, 0, 0, 0));
        step("wr_ds_ignored2", pk(S_DATA, 1, 0, 4'hE, 0, 0, 0, 0));
        FCS_n = 1'b1; DS_n_in = 4'hF; DOE = 1'b0;
        step("wr_rel1", pk(S_DATA, 1, 0, 4'hE, 0, 0, 0, 0));
        step("wr_rel2", pk(S_DATA, 1, 0, 4'hE, 0, 0, 0, 0));
        step("wr_end", pk(S_END, 0, 0, 4'hE, 1, 1, 0, 0));
        step("wr_idle", W_IDLE);

        // Unmatched address
        READ = 1'b1; ADDR = {4'h5, 26'h0}; FCS_n = 1'b0;
        step("um_sync1", W_IDLE);
        step("um_sync2", W_IDLE);
        for (int i = 0; i < 4; i++) step("um_end_hold", pk(S_END, 0, 1, 4'hF, 1, 1, 0, 0));
        FCS_n = 1'b1;
        step("um_rel1", pk(S_END, 0, 1, 4'hF, 1, 1, 0, 0));
        step("um_rel2", pk(S_END, 0, 1, 4'hF, 1, 1, 0, 0));
        step("um_idle", W_IDLE);

        // Abort in START
        ADDR = {4'h4, 26'h0}; FCS_n = 1'b0;
        step("ab_sync1", W_IDLE);
        step("ab_sync2", W_IDLE);
        step("ab_start", pk(S_START, 1, 1, 4'hF, 0, 1, 0, 0));
        FCS_n = 1'b1;
        step("ab_rel1", pk(S_START, 1, 1, 4'hF, 0, 1, 0, 0));
        step("ab_rel2", pk(S_START, 1, 1, 4'hF, 0, 1, 0, 0));
        step("ab_idle", W_IDLE);
        step("ab_idle_hold", W_IDLE);

        // Watchdog expiry with no dtack
        FCS_n = 1'b0;
        step("to_sync1", W_IDLE);
        step("to_sync2", W_IDLE);
        step("to_start", pk(S_START, 1, 1, 4'hF, 0, 1, 0, 0));
        DS_n_in = 4'h0; DOE = 1'b1;
        step("to_ds1", pk(S_START, 1, 1, 4'hF, 0, 1, 0, 0));
        step("to_ds2", pk(S_START, 1, 1, 4'hF, 0, 1, 0, 0));
        step("to_data", pk(S_DATA, 1, 1, 4'h0, 0, 1, 0, 0));
        for (int i = 1; i < 255; i++) step("to_wait", pk(S_DATA, 1, 1, 4'h0, 0, 1, 1, 0));
        step("to_fire", pk(S_END, 0, 1, 4'h0, 1, 1, 0, 1));
        step("to_pulse_end", pk(S_END, 0, 1, 4'h0, 1, 1, 0, 0));
        FCS_n = 1'b1; DS_n_in = 4'hF; DOE = 1'b0;
        step("to_rel1", pk(S_END, 0, 1, 4'h0, 1, 1, 0, 0));
        step("to_rel2", pk(S_END, 0, 1, 4'h0, 1, 1, 0, 0));
        step("to_idle", W_IDLE);

        // dtack arriving on the expiry cycle wins over the watchdog
        FCS_n = 1'b0;
        step("tw_sync1", W_IDLE);
        step("tw_sync2", W_IDLE);
        step("tw_start", pk(S_START, 1, 1, 4'hF, 0, 1, 0, 0));
        DS_n_in = 4'h0; DOE = 1'b1;
        step("tw_ds1", pk(S_START, 1, 1, 4'hF, 0, 1, 0, 0));
        step("tw_ds2", pk(S_START, 1, 1, 4'hF, 0, 1, 0, 0));
        step("tw_data", pk(S_DATA, 1, 1, 4'h0, 0, 1, 0, 0));
        for (int i = 1; i < 255; i++) step("tw_wait", pk(S_DATA, 1, 1, 4'h0, 0, 1, 1, 0));
        dtack = 1'b1;
        step("tw_dtack_wins", pk(S_DATA, 1, 1, 4'h0, 0, 0, 1, 0));
        dtack = 1'b0;
        step("tw_dtack_hold", pk(S_DATA, 1, 1, 4'h0, 0, 0, 1, 0));

        // Reset mid-DATA with DTACK_n low, then unconfigured card ignores a matching address
        RESET_n = 1'b0;
        step("rs_mid", W_IDLE);
        RESET_n = 1'b1; configured = 1'b0;
        step("rs_sync1", W_IDLE);
        step("rs_sync2", W_IDLE);
        step("rs_nocfg_end", pk(S_END, 0, 1, 4'hF, 1, 1, 0, 0));
        step("rs_nocfg_hold", pk(S_END, 0, 1, 4'hF, 1, 1, 0, 0));
        FCS_n = 1'b1; DS_n_in = 4'hF; DOE = 1'b0;
        step("rs_rel1", pk(S_END, 0, 1, 4'hF, 1, 1, 0, 0));
        step("rs_rel2", pk(S_END, 0, 1, 4'hF, 1, 1, 0, 0));
        step("rs_idle", W_IDLE);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: bench did not complete within time limit");
        $fatal(1);
    end

endmodule
